// File: rtl/fetch_pc_if.sv
// Fetch-stage bus: instruction bytes and PC-update inputs in, decoded fields and status out.
interface fetch_pc_if #(
    parameter int unsigned CNT_W = 32
);
    logic [7:0]       byte0;
    logic [7:0]       byte1;
    logic [7:0]       byte2;
    logic [7:0]       byte3;
    logic [7:0]       byte4;
    logic [7:0]       byte5;
    logic [7:0]       byte6;
    logic [7:0]       byte7;
    logic [7:0]       byte8;
    logic [7:0]       byte9;
    logic             imem_error;
    logic             step_en;
    logic [63:0]      new_pc;
    logic [63:0]      PC;
    logic [3:0]       icode;
    logic [3:0]       ifun;
    logic [3:0]       rA;
    logic [3:0]       rB;
    logic [63:0]      valC;
    logic [63:0]      valP;
    logic             instr_valid;
    logic [2:0]       stat;
    logic [CNT_W-1:0] fetch_count;

    // Memory / PC-update side
    modport master (
        output byte0, byte1, byte2, byte3, byte4, byte5, byte6, byte7, byte8, byte9,
        output imem_error, step_en, new_pc,
        input  PC, icode, ifun, rA, rB, valC, valP, instr_valid, stat, fetch_count
    );

    // Fetch stage side
    modport slave (
        input  byte0, byte1, byte2, byte3, byte4, byte5, byte6, byte7, byte8, byte9,
        input  imem_error, step_en, new_pc,
        output PC, icode, ifun, rA, rB, valC, valP, instr_valid, stat, fetch_count
    );
endinterface

// File: rtl/fetch_pc_stage.sv
// Y86-64 SEQ fetch: PC register, instruction split/validation, sticky status.
module fetch_pc_stage #(
    parameter logic [63:0] RESET_PC = 64'd0,
    parameter int unsigned CNT_W    = 32
) (
    input  logic        clk,
    input  logic        reset,
    fetch_pc_if.slave   bus
);
    typedef enum logic [2:0] {
        S_AOK = 3'd1,
        S_HLT = 3'd2,
        S_ADR = 3'd3,
        S_INS = 3'd4
    } stat_e;

    stat_e            stat_q, stat_d;
    logic [63:0]      pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [3:0]  icode, ifun;
    logic        need_regids, need_valC, instr_valid;
    logic [63:0] valC, valP;

    assign icode = bus.byte0[7:4];
    assign ifun  = bus.byte0[3:0];

    // Field classification and encoding legality
    always_comb begin
        need_regids = 1'b0;
        need_valC   = 1'b0;
        instr_valid = 1'b0;
        case (icode)
            4'h2, 4'h6, 4'hA, 4'hB: need_regids = 1'b1;
            4'h3, 4'h4, 4'h5:       begin need_regids = 1'b1; need_valC = 1'b1; end
            4'h7, 4'h8:             need_valC = 1'b1;
            default:                ;
        endcase
        case (icode)
            4'h0, 4'h1, 4'h3, 4'h4, 4'h5,
            4'h8, 4'h9, 4'hA, 4'hB: instr_valid = (ifun == 4'h0);
            4'h2, 4'h7:             instr_valid = (ifun <= 4'h6);
            4'h6:                   instr_valid = (ifun <= 4'h3);
            default:                instr_valid = 1'b0;
        endcase
    end

    // Constant word and sequential next address (wraps mod 2^64)
    always_comb begin
        valC = 64'd0;
        if (need_valC) begin
            valC = need_regids
                 ? {bus.byte9, bus.byte8, bus.byte7, bus.byte6,
                    bus.byte5, bus.byte4, bus.byte3, bus.byte2}
                 : {bus.byte8, bus.byte7, bus.byte6, bus.byte5,
                    bus.byte4, bus.byte3, bus.byte2, bus.byte1};
        end
        valP = pc_q + 64'd1 + 64'(need_regids) + (need_valC ? 64'd8 : 64'd0);
    end

    // Status next-state, PC load and commit counting
    always_comb begin
        stat_d = stat_q;
        pc_d   = pc_q;
        cnt_d  = cnt_q;
        if (stat_q == S_AOK && bus.step_en) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (bus.imem_error)  stat_d = S_ADR;
            else if (!instr_valid) stat_d = S_INS;
            else if (icode == 4'h0) stat_d = S_HLT;
            else                   pc_d   = bus.new_pc;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_q <= S_AOK;
            pc_q   <= RESET_PC;
            cnt_q  <= '0;
        end else begin
            stat_q <= stat_d;
            pc_q   <= pc_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.PC          = pc_q;
    assign bus.stat        = stat_q;
    assign bus.fetch_count = cnt_q;
    assign bus.icode       = icode;
    assign bus.ifun        = ifun;
    assign bus.rA          = need_regids ? bus.byte1[7:4] : 4'hF;
    assign bus.rB          = need_regids ? bus.byte1[3:0] : 4'hF;
    assign bus.valC        = valC;
    assign bus.valP        = valP;
    assign bus.instr_valid = instr_valid;
endmodule

// File: tb/tb_fetch_pc_stage.sv
// Directed bench for fetch_pc_stage with hand-computed expectations.
module tb_fetch_pc_stage;
    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;

    fetch_pc_if #(.CNT_W(32)) bus ();

    fetch_pc_stage #(.RESET_PC(64'd0), .CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Count one comparison and report it if it misses
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Load byte0..byte9 from an 80-bit word, byte0 in the top byte
    task automatic set_bytes(input logic [79:0] b);
        bus.byte0 = b[79:72]; bus.byte1 = b[71:64];
        bus.byte2 = b[63:56]; bus.byte3 = b[55:48];
        bus.byte4 = b[47:40]; bus.byte5 = b[39:32];
        bus.byte6 = b[31:24]; bus.byte7 = b[23:16];
        bus.byte8 = b[15:8];  bus.byte9 = b[7:0];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Commit one instruction with the given first byte and next PC
    task automatic step(input logic [7:0] b0, input logic [63:0] npc);
        set_bytes({b0, 72'd0});
        bus.new_pc  = npc;
        bus.step_en = 1'b1;
        tick();
        bus.step_en = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic check_regs(input string tag, input logic [63:0] pc, input logic [2:0] st,
                              input logic [31:0] cnt);
        check({tag, ".PC"},   bus.PC, pc);
        check({tag, ".stat"}, 64'(bus.stat), 64'(st));
        check({tag, ".cnt"},  64'(bus.fetch_count), 64'(cnt));
    endtask

    logic [7:0] vb0 [8];
    logic       vok [8];

    initial begin
        reset = 1'b1;
        bus.step_en = 1'b0;
        bus.imem_error = 1'b0;
        bus.new_pc = 64'd0;
        set_bytes(80'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        check_regs("reset", 64'd0, 3'd1, 32'd0);

        // step_en low holds everything
        bus.new_pc = 64'h77;
        set_bytes({8'h10, 72'd0});
        tick();
        check_regs("hold", 64'd0, 3'd1, 32'd0);

        // nop to reach 0x10, then irmovq decode
        step(8'h10, 64'h10);
        check_regs("nop", 64'h10, 3'd1, 32'd1);
        set_bytes(80'h30_F3_EF_CD_AB_89_67_45_23_01);
        #1;
        check("irm.icode", 64'(bus.icode), 64'h3);
        check("irm.ifun",  64'(bus.ifun), 64'h0);
        check("irm.rA",    64'(bus.rA), 64'hF);
        check("irm.rB",    64'(bus.rB), 64'h3);
        check("irm.valC",  bus.valC, 64'h0123456789ABCDEF);
        check("irm.valP",  bus.valP, 64'h1A);
        check("irm.valid", 64'(bus.instr_valid), 64'd1);
        bus.new_pc  = 64'h1A;
        bus.step_en = 1'b1;
        tick();
        bus.step_en = 1'b0;
        check_regs("irm", 64'h1A, 3'd1, 32'd2);

        // call at 0x40
        step(8'h10, 64'h40);
        set_bytes(80'h80_00_01_00_00_00_00_00_00_00);
        #1;
        check("call.rA",    64'(bus.rA), 64'hF);
        check("call.rB",    64'(bus.rB), 64'hF);
        check("call.valC",  bus.valC, 64'h100);
        check("call.valP",  bus.valP, 64'h49);
        check("call.valid", 64'(bus.instr_valid), 64'd1);

        // rrmovq: regids, no constant
        set_bytes(80'h20_12_FF_FF_FF_FF_FF_FF_FF_FF);
        #1;
        check("rr.valC", bus.valC, 64'd0);
        check("rr.valP", bus.valP, 64'h42);
        check("rr.rA",   64'(bus.rA), 64'h1);

        // Encoding legality table
        vb0 = '{8'h26, 8'h27, 8'h63, 8'h64, 8'hC0, 8'h11, 8'h90, 8'hB0};
        vok = '{1'b1,  1'b0,  1'b1,  1'b0,  1'b0,  1'b0,  1'b1,  1'b1};
        for (int i = 0; i < 8; i++) begin
            set_bytes({vb0[i], 72'd0});
            #1;
            check($sformatf("valid[%h]", vb0[i]), 64'(bus.instr_valid), 64'(vok[i]));
        end

        // valP wraps past 2^64
        step(8'h10, 64'hFFFF_FFFF_FFFF_FFFF);
        set_bytes(80'h30_F3_00_00_00_00_00_00_00_00);
        #1;
        check("wrap.valP", bus.valP, 64'h9);

        // halt freezes PC, counts the fetch, then ignores steps
        step(8'h00, 64'h1234);
        check_regs("halt", 64'hFFFF_FFFF_FFFF_FFFF, 3'd2, 32'd5);
        step(8'h10, 64'h1234);
        step(8'h10, 64'h1234);
        check_regs("halt2", 64'hFFFF_FFFF_FFFF_FFFF, 3'd2, 32'd5);

        // illegal encodings
        do_reset();
        step(8'h64, 64'h99);
        check_regs("ins64", 64'd0, 3'd4, 32'd1);
        do_reset();
        step(8'hC0, 64'h99);
        check_regs("insC0", 64'd0, 3'd4, 32'd1);

        // ADR wins over HLT
        do_reset();
        bus.imem_error = 1'b1;
        step(8'h00, 64'h99);
        bus.imem_error = 1'b0;
        check_regs("adr", 64'd0, 3'd3, 32'd1);

        // reset from ADR with step_en high: reset wins
        set_bytes({8'h10, 72'd0});
        bus.new_pc  = 64'h55;
        bus.step_en = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.step_en = 1'b0;
        check_regs("rst_adr", 64'd0, 3'd1, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fetch_pc_stage.md
Name: fetch_pc_stage

Overview:
Downstream consumer of the instruction memory in the SEQ Y86-64 processor. Holds the architectural PC register and presents it to instruction memory. Splits the 10 fetched bytes into icode/ifun/rA/rB/valC, computes valP and validates the encoding. Keeps a sticky processor status register that freezes the PC on halt or fault.

Parameters:
RESET_PC, 64'd0, PC value loaded on reset
CNT_W, 32, width of the fetched-instruction counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
byte0..byte9  in  8 each  instruction bytes at PC..PC+9 from instruction memory
imem_error  in  1  instruction memory address fault for current PC
step_en  in  1  commit current instruction and load next PC this edge
new_pc  in  64  next PC selected by the PC-update logic (valP/valC/valM)
PC  out  64  registered architectural PC, drives instruction memory address
icode  out  4  byte0[7:4]
ifun  out  4  byte0[3:0]
rA  out  4  byte1[7:4] if regids needed, else 4'hF
rB  out  4  byte1[3:0] if regids needed, else 4'hF
valC  out  64  constant word, little-endian
valP  out  64  address of next sequential instruction
instr_valid  out  1  encoding legal
stat  out  3  registered status: 1 AOK, 2 HLT, 3 ADR, 4 INS
fetch_count  out  CNT_W  number of committed fetches

Behaviour:
- Reset (sync, high, on clk edge): PC=RESET_PC, stat=AOK(1), fetch_count=0. Reset overrides step_en. Reset mid-run discards any fault state.
- icode/ifun/rA/rB/valC/valP/instr_valid are combinational from byte0..9 and PC, zero-latency. They are not gated by stat.
- need_regids = icode in {2,3,4,5,6,A,B}. need_valC = icode in {3,4,5,7,8}.
- valC: if need_regids, bytes 2..9 (byte2 = LSB). Else bytes 1..8 (byte1 = LSB). valC=0 when need_valC=0.
- valP = PC + 1 + need_regids + 8*need_valC. Computed modulo 2^64; wrap allowed and no fault raised.
- instr_valid = 0 if icode > 4'hB.
- instr_valid = 0 if icode in {0,1,3,4,5,8,9,A,B} and ifun != 0.
- instr_valid = 0 if icode in {2,7} and ifun > 6.
- instr_valid = 0 if icode == 6 and ifun > 3.
- instr_valid = 1 otherwise.
- Status FSM, states AOK/HLT/ADR/INS. Evaluated on clk edge only when step_en=1 and stat==AOK:
  - imem_error=1 -> ADR.
  - else instr_valid=0 -> INS.
  - else icode==0 -> HLT.
  - else stay AOK.
  - Priority: ADR > INS > HLT.
- HLT, ADR and INS are terminal; only reset leaves them.
- PC update: on edge with step_en=1 and stat==AOK and the next state is AOK, PC <= new_pc and fetch_count increments by 1.
- A faulting or halting instruction does not advance PC. It still increments fetch_count. PC then holds the offending address.
- step_en=0: PC, stat and fetch_count hold.
- In any non-AOK state, step_en is ignored and all registers hold.
- fetch_count wraps at 2^CNT_W-1 -> 0.

Test Plan:
- Reset with RESET_PC=0 -> PC=0, stat=1, fetch_count=0 on the cycle after reset deasserts.
- irmovq: bytes 30 F3 EF CD AB 89 67 45 23 01, PC=0x10 -> rA=F, rB=3, valC=0x0123456789ABCDEF, valP=0x1A, instr_valid=1. With step_en and new_pc=0x1A, PC becomes 0x1A next edge.
- jXX/call: byte0=0x80, bytes1..8 = 00 01 00..00, PC=0x40 -> rA=rB=F, valC=0x100, valP=0x49.
- halt: byte0=0x00 with step_en=1 -> stat=2, PC unchanged, fetch_count+1. Further step_en pulses cause no change to PC or fetch_count.
- Illegal encodings: byte0=0x64 -> stat=4. Separately, byte0=0xC0 -> stat=4. imem_error=1 together with byte0=0x00 -> stat=3 (ADR wins).
- Synchronous reset asserted while stat=3 -> next edge gives stat=1, PC=RESET_PC, fetch_count=0. reset and step_en together -> reset wins.
